// File: rtl/keypad_if.sv
// Key event channel between the keypad scanner and its consumer.
// The scanner drives the event and status lines; the consumer returns key_ready.
interface keypad_if #(
  parameter int KW = 4
) ();
  logic [KW-1:0] key_code;
  logic          key_valid;
  logic          key_ready;
  logic          key_held;
  logic          multi_key;
  logic          overrun;

  modport master (
    output key_code, key_valid, key_held, multi_key, overrun,
    input  key_ready
  );

  modport slave (
    input  key_code, key_valid, key_held, multi_key, overrun,
    output key_ready
  );
endinterface

// File: rtl/keypad_scanner.sv
// Matrix keypad scanner: one-hot row strobes, synchronised column sense,
// press/release debounce, chord suppression and a valid/ready key event.
//
// state    | meaning
// SCAN     | strobe rows in turn, sample columns on the last dwell cycle
// DEBOUNCE | row locked, count consecutive samples equal to the captured pattern
// HELD     | key or chord accepted, row locked, count consecutive all-zero samples
module keypad_scanner #(
  parameter int ROWS            = 4,
  parameter int COLS            = 4,
  parameter int SCAN_CYCLES     = 4,
  parameter int DEBOUNCE_CYCLES = 8,
  localparam int KW = ($clog2(ROWS * COLS) > 1) ? $clog2(ROWS * COLS) : 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [COLS-1:0] col_in,
  output logic [ROWS-1:0] row_out,
  keypad_if.master        kp
);

  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int DW = $clog2(SCAN_CYCLES);
  localparam int BW = $clog2(DEBOUNCE_CYCLES + 1);

  localparam logic [RW-1:0] ROW_LAST   = RW'(ROWS - 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_CYCLES - 1);
  localparam logic [BW-1:0] DB_LAST    = BW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD} state_t;

  logic [COLS-1:0] sync1_q, col_s_q;
  state_t          state_q, state_d;
  logic [RW-1:0]   row_q, row_d, row_next;
  logic [DW-1:0]   dwell_q, dwell_d;
  logic [BW-1:0]   cnt_q, cnt_d;
  logic [COLS-1:0] pat_q, pat_d;
  logic            valid_q, valid_d;
  logic [KW-1:0]   code_q, code_d;
  logic            held_q, held_d;
  logic            multi_q, multi_d;
  logic            overrun_q, overrun_d;

  logic            ev;
  logic            pat_onehot;
  logic [CW-1:0]   pat_idx;
  logic [KW-1:0]   ev_code;

  always_comb begin
    pat_idx = '0;
    for (int c = 0; c < COLS; c++) begin
      if (pat_q[c]) pat_idx = CW'(c);
    end
  end

  assign pat_onehot = (pat_q != '0) && ((pat_q & (pat_q - 1'b1)) == '0);
  assign ev_code    = KW'(int'(row_q) * COLS + int'(pat_idx));
  assign row_next   = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    dwell_d   = dwell_q;
    cnt_d     = cnt_q;
    pat_d     = pat_q;
    held_d    = held_q;
    multi_d   = multi_q;
    ev        = 1'b0;

    unique case (state_q)
      SCAN: begin
        if (dwell_q == DWELL_LAST) begin
          dwell_d = '0;
          if (col_s_q == '0) begin
            row_d = row_next;
          end else begin
            pat_d   = col_s_q;
            cnt_d   = BW'(1);
            state_d = DEBOUNCE;
          end
        end else begin
          dwell_d = dwell_q + 1'b1;
        end
      end
      DEBOUNCE: begin
        if (col_s_q == pat_q) begin
          if (cnt_q == DB_LAST) begin
            state_d = HELD;
            cnt_d   = '0;
            if (pat_onehot) begin
              ev     = 1'b1;
              held_d = 1'b1;
            end else begin
              multi_d = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else begin
          state_d = SCAN;
          row_d   = row_next;
          dwell_d = '0;
        end
      end
      HELD: begin
        // Release needs an unbroken run of all-zero samples.
        if (col_s_q == '0) begin
          if (cnt_q == DB_LAST) begin
            state_d = SCAN;
            row_d   = row_next;
            dwell_d = '0;
            cnt_d   = '0;
            held_d  = 1'b0;
            multi_d = 1'b0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else begin
          cnt_d = '0;
        end
      end
      default: state_d = SCAN;
    endcase
  end

  always_comb begin
    valid_d   = valid_q;
    code_d    = code_q;
    overrun_d = 1'b0;
    if (ev) begin
      // An unconsumed event wins; the new one is dropped and flagged.
      if (valid_q && !kp.key_ready) begin
        overrun_d = 1'b1;
      end else begin
        valid_d = 1'b1;
        code_d  = ev_code;
      end
    end else if (valid_q && kp.key_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q   <= '0;
      col_s_q   <= '0;
      state_q   <= SCAN;
      row_q     <= '0;
      dwell_q   <= '0;
      cnt_q     <= '0;
      pat_q     <= '0;
      valid_q   <= 1'b0;
      code_q    <= '0;
      held_q    <= 1'b0;
      multi_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      sync1_q   <= col_in;
      col_s_q   <= sync1_q;
      state_q   <= state_d;
      row_q     <= row_d;
      dwell_q   <= dwell_d;
      cnt_q     <= cnt_d;
      pat_q     <= pat_d;
      valid_q   <= valid_d;
      code_q    <= code_d;
      held_q    <= held_d;
      multi_q   <= multi_d;
      overrun_q <= overrun_d;
    end
  end

  assign row_out      = ROWS'(1) << row_q;
  assign kp.key_code  = code_q;
  assign kp.key_valid = valid_q;
  assign kp.key_held  = held_q;
  assign kp.multi_key = multi_q;
  assign kp.overrun   = overrun_q;

endmodule
